gray_seq_monitor: RTL and testbench

- Downstream consumer of the 4-bit binary-to-Gray stage.
- Registers each Gray-coded sample, converts it back to binary, and classifies each sample against the previous one as a repeat, a +1 step or a −1 step (mod 2^WIDTH).
- Illegal jumps are flagged and counted.
- Keeps a wrapping position accumulator, for use as a pointer/encoder integrity checker.

---
 rtl/gray_seq_monitor.sv | 113 +++++++++++
 tb/tb_gray_seq_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_seq_monitor.sv
// Gray-code sequence checker: decodes each sample, classifies it as repeat/+1/-1/illegal, tracks position and errors.
// One-cycle registered latency on every output; no back-pressure, every gray_valid cycle is taken unless clr is high.
module gray_seq_monitor #(
    parameter int WIDTH = 4,
    parameter int POS_W = 8,
    parameter int ERR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             gray_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [POS_W-1:0] pos,
    output logic             locked
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        FAULT = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] last_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] diff;
    logic             is_rep;
    logic             is_up;
    logic             is_dn;
    logic [ERR_W-1:0] err_cnt_sat;

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray_in >> i);
        end
    end

    assign diff        = bin - last_bin;
    assign is_rep      = (diff == '0);
    assign is_up       = (diff == WIDTH'(1));
    assign is_dn       = (diff == '1);
    assign err_cnt_sat = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_bin  <= '0;
            bin_out   <= '0;
            bin_valid <= 1'b0;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            pos       <= '0;
            locked    <= 1'b0;
        end else begin
            bin_valid <= 1'b0;
            step_up   <= 1'b0;
            step_dn   <= 1'b0;
            err       <= 1'b0;
            if (clr) begin
                // bin_out deliberately holds across a clear
                state   <= IDLE;
                pos     <= '0;
                err_cnt <= '0;
                locked  <= 1'b0;
            end else if (gray_valid) begin
                bin_out   <= bin;
                last_bin  <= bin;
                bin_valid <= 1'b1;
                case (state)
                    IDLE: begin
                        state  <= TRACK;
                        locked <= 1'b1;
                    end
                    TRACK: begin
                        if (is_up) begin
                            step_up <= 1'b1;
                            pos     <= pos + POS_W'(1);
                        end else if (is_dn) begin
                            step_dn <= 1'b1;
                            pos     <= pos - POS_W'(1);
                        end else if (!is_rep) begin
                            err     <= 1'b1;
                            err_cnt <= err_cnt_sat;
                            state   <= FAULT;
                            locked  <= 1'b0;
                        end
                    end
                    FAULT: begin
                        if (!(is_rep || is_up || is_dn)) begin
                            err     <= 1'b1;
                            err_cnt <= err_cnt_sat;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Bench for gray_seq_monitor: directed vector table, hand-written reset/repeat sequence, then random traffic vs a reference model.
module tb_gray_seq_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gray_in = '0;
    logic       gray_valid = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic       step_up;
    logic       step_dn;
    logic       err;
    logic [3:0] err_cnt;
    logic [7:0] pos;
    logic       locked;

    int n_chk  = 0;
    int n_fail = 0;

    gray_seq_monitor #(.WIDTH(4), .POS_W(8), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .gray_in(gray_in), .gray_valid(gray_valid), .clr(clr),
        .bin_out(bin_out), .bin_valid(bin_valid), .step_up(step_up), .step_dn(step_dn),
        .err(err), .err_cnt(err_cnt), .pos(pos), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         c;
        bit         v;
        logic [3:0] g;
        int         e_bin;
        bit         e_bv;
        bit         e_up;
        bit         e_dn;
        bit         e_err;
        int         e_cnt;
        int         e_pos;
        bit         e_lock;
    } vec_t;

    vec_t tbl[$];

    // Reference model: plain integer arithmetic on the decoded values
    int m_st, m_last, m_bin, m_cnt, m_pos;
    bit m_bv, m_up, m_dn, m_err, m_lock;

    function automatic int b2g(int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    function automatic int g2b(int g);
        int b = 0;
        for (int s = 0; s < 4; s++) b = b ^ (g >> s);
        return b & 15;
    endfunction

    function automatic vec_t mk(bit c, bit v, int g, int eb, bit ebv, bit eu, bit ed, bit ee,
                                int ec, int ep, bit el);
        vec_t r;
        r.c = c; r.v = v; r.g = 4'(g); r.e_bin = eb; r.e_bv = ebv; r.e_up = eu;
        r.e_dn = ed; r.e_err = ee; r.e_cnt = ec; r.e_pos = ep; r.e_lock = el;
        return r;
    endfunction

    function automatic void m_reset();
        m_st = 0; m_last = 0; m_bin = 0; m_cnt = 0; m_pos = 0;
        m_bv = 0; m_up = 0; m_dn = 0; m_err = 0; m_lock = 0;
    endfunction

    function automatic void model(bit c, bit v, int b);
        int d;
        m_bv = 0; m_up = 0; m_dn = 0; m_err = 0;
        if (c) begin
            m_st = 0; m_pos = 0; m_cnt = 0;
        end else if (v) begin
            m_bv = 1;
            d = (b - m_last + 16) % 16;
            m_bin = b;
            m_last = b;
            if (m_st == 0) begin
                m_st = 1;
            end else if (d == 1 && m_st == 1) begin
                m_up = 1; m_pos = (m_pos + 1) % 256;
            end else if (d == 15 && m_st == 1) begin
                m_dn = 1; m_pos = (m_pos + 255) % 256;
            end else if (d != 0 && d != 1 && d != 15) begin
                m_err = 1; m_st = 2;
                if (m_cnt < 15) m_cnt = m_cnt + 1;
            end
        end
        m_lock = (m_st == 1);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_model(string nm);
        chk({nm, " bin_out"},   int'(bin_out),   m_bin);
        chk({nm, " bin_valid"}, int'(bin_valid), int'(m_bv));
        chk({nm, " step_up"},   int'(step_up),   int'(m_up));
        chk({nm, " step_dn"},   int'(step_dn),   int'(m_dn));
        chk({nm, " err"},       int'(err),       int'(m_err));
        chk({nm, " err_cnt"},   int'(err_cnt),   m_cnt);
        chk({nm, " pos"},       int'(pos),       m_pos);
        chk({nm, " locked"},    int'(locked),    int'(m_lock));
    endtask

    task automatic drive(bit c, bit v, int g);
        clr = c; gray_valid = v; gray_in = 4'(g);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int b, lb, nb, r;
        bit c, v;

        // Directed table
        for (int i = 0; i <= 16; i++)
            tbl.push_back(mk(0, 1, b2g(i % 16), i % 16, 1, i > 0, 0, 0, 0, i, 1));
        tbl.push_back(mk(0, 0, 0,       0, 0, 0, 0, 0, 0, 16, 1));
        tbl.push_back(mk(1, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b1000, 15, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'b1001, 14, 1, 0, 1, 0, 0, 255, 1));
        tbl.push_back(mk(1, 0, 0,       14, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0001, 1, 1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4'b0010, 3, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 4'b0110, 4, 1, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < 20; k++)
            tbl.push_back(mk(0, 1, (k % 2 == 0) ? 4'b0000 : 4'b0101, (k % 2 == 0) ? 0 : 6,
                             1, 0, 0, 1, (k + 2 > 15) ? 15 : k + 2, 0, 0));
        tbl.push_back(mk(1, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i <= 5; i++)
            tbl.push_back(mk(0, 1, b2g(i), i, 1, i > 0, 0, 0, 0, i, 1));
        tbl.push_back(mk(0, 1, b2g(9), 9, 1, 0, 0, 1, 1, 5, 0));
        tbl.push_back(mk(0, 1, b2g(0), 0, 1, 0, 0, 1, 2, 5, 0));
        tbl.push_back(mk(0, 1, b2g(9), 9, 1, 0, 0, 1, 3, 5, 0));
        tbl.push_back(mk(1, 1, b2g(1), 9, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, b2g(3), 3, 1, 0, 0, 0, 0, 0, 1));

        // Reset state, checked before any clock edge
        #1;
        chk("reset bin_out", int'(bin_out), 0);
        chk("reset bin_valid", int'(bin_valid), 0);
        chk("reset err_cnt", int'(err_cnt), 0);
        chk("reset pos", int'(pos), 0);
        chk("reset locked", int'(locked), 0);
        #11 rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].c, tbl[i].v, int'(tbl[i].g));
            chk($sformatf("vec%0d bin_out", i),   int'(bin_out),   tbl[i].e_bin);
            chk($sformatf("vec%0d bin_valid", i), int'(bin_valid), int'(tbl[i].e_bv));
            chk($sformatf("vec%0d step_up", i),   int'(step_up),   int'(tbl[i].e_up));
            chk($sformatf("vec%0d step_dn", i),   int'(step_dn),   int'(tbl[i].e_dn));
            chk($sformatf("vec%0d err", i),       int'(err),       int'(tbl[i].e_err));
            chk($sformatf("vec%0d err_cnt", i),   int'(err_cnt),   tbl[i].e_cnt);
            chk($sformatf("vec%0d pos", i),       int'(pos),       tbl[i].e_pos);
            chk($sformatf("vec%0d locked", i),    int'(locked),    int'(tbl[i].e_lock));
        end

        // Repeat sample, then asynchronous reset between edges
        m_reset();
        m_bin = 3;
        drive(1, 0, 0);            model(1, 0, 0);           chk_model("hs clr");
        drive(0, 1, b2g(2));       model(0, 1, 2);           chk_model("hs seed");
        drive(0, 1, b2g(2));       model(0, 1, 2);
        chk("repeat bin_valid", int'(bin_valid), 1);
        chk("repeat step_up", int'(step_up), 0);
        chk("repeat step_dn", int'(step_dn), 0);
        chk("repeat err", int'(err), 0);
        drive(0, 1, b2g(3));       model(0, 1, 3);
        chk("hs up pos", int'(pos), 1);
        drive(0, 1, b2g(9));       model(0, 1, 9);
        chk("hs jump err_cnt", int'(err_cnt), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst bin_out", int'(bin_out), 0);
        chk("arst bin_valid", int'(bin_valid), 0);
        chk("arst step_up", int'(step_up), 0);
        chk("arst step_dn", int'(step_dn), 0);
        chk("arst err", int'(err), 0);
        chk("arst err_cnt", int'(err_cnt), 0);
        chk("arst pos", int'(pos), 0);
        chk("arst locked", int'(locked), 0);
        m_reset();
        #2 rst = 1'b0;
        drive(0, 1, b2g(5));       model(0, 1, 5);
        chk("reseed locked", int'(locked), 1);
        chk("reseed step_up", int'(step_up), 0);
        chk("reseed err", int'(err), 0);
        chk("reseed pos", int'(pos), 0);

        // Random traffic, mostly legal steps with occasional jumps and clears
        lb = 5;
        for (int n = 0; n < 3000; n++) begin
            c = ($urandom_range(0, 49) == 0);
            v = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 3)      nb = lb;
            else if (r < 6) nb = (lb + 1) % 16;
            else if (r < 9) nb = (lb + 15) % 16;
            else            nb = $urandom_range(0, 15);
            drive(c, v, b2g(nb));
            b = g2b(b2g(nb));
            model(c, v, b);
            if (v && !c) lb = nb;
            chk_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
